// File: rtl/lvds_pkg.sv
// Shared definitions for the LVDS receive word-alignment controller.
package lvds_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_SLIP  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_NEXT  = 3'd4,
        ST_DONE  = 3'd5,
        ST_FAIL  = 3'd6
    } lvds_state_e;

    localparam logic [7:0] LVDS_TRAIN_PAT = 8'h5C;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int v = value - 1; v > 0; v = v >>> 1) begin
            res = res + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/lvds_lane_mux.sv
// Selects the word of the lane under training and steers the slip strobe to
// that lane's BITSLIP bit.
module lvds_lane_mux
    import lvds_pkg::*;
#(
    parameter int C_DATA_WIDTH = 8,
    parameter int LW           = 3
) (
    input  logic [C_DATA_WIDTH*8-1:0] rx_q,
    input  logic [LW-1:0]             lane,
    input  logic                      slip,
    output logic [7:0]                word,
    output logic [C_DATA_WIDTH-1:0]   lane_oh,
    output logic [C_DATA_WIDTH-1:0]   bitslip
);

    // Lane word select and one-hot lane decode
    always_comb begin
        word    = 8'h00;
        lane_oh = '0;
        bitslip = '0;
        for (int i = 0; i < C_DATA_WIDTH; i++) begin
            if (lane == LW'(i)) begin
                word       = rx_q[8*i +: 8];
                lane_oh[i] = 1'b1;
            end else begin
                lane_oh[i] = 1'b0;
            end
        end
        if (slip) begin
            bitslip = lane_oh;
        end else begin
            bitslip = '0;
        end
    end

endmodule

// File: rtl/lvds_rx_align.sv
// LVDS receive word alignment: slips each lane in turn until it shows the
// training word for P_MATCH_CNT consecutive words, then forwards data.
module lvds_rx_align
    import lvds_pkg::*;
#(
    parameter int          C_DATA_WIDTH = 8,
    parameter logic [7:0]  P_TRAIN_PAT  = LVDS_TRAIN_PAT,
    parameter int          P_SLIP_WAIT  = 4,
    parameter int          P_MATCH_CNT  = 16,
    parameter int          P_MAX_SLIP   = 8,
    localparam int         LW           = (C_DATA_WIDTH > 1) ? clog2(C_DATA_WIDTH) : 1
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      START,
    input  logic [C_DATA_WIDTH*8-1:0] RX_DAT,
    output logic [C_DATA_WIDTH-1:0]   BITSLIP,
    output logic [C_DATA_WIDTH-1:0]   LANE_LOCK,
    output logic                      ALIGN_DONE,
    output logic                      ALIGN_FAIL,
    output logic [LW-1:0]             FAIL_LANE,
    output logic [C_DATA_WIDTH*8-1:0] RX_DAT_O,
    output logic                      RX_VLD
);

    localparam int SW = clog2(P_MAX_SLIP + 1);
    localparam int MW = clog2(P_MATCH_CNT + 1);
    localparam int WW = clog2(P_SLIP_WAIT + 1);

    lvds_state_e               state_r;
    logic [C_DATA_WIDTH*8-1:0] rx_q_r;
    logic [LW-1:0]             lane_r;
    logic [SW-1:0]             slip_cnt_r;
    logic [MW-1:0]             match_cnt_r;
    logic [WW-1:0]             wait_cnt_r;
    logic [7:0]                word_s;
    logic [C_DATA_WIDTH-1:0]   lane_oh_s;
    logic [C_DATA_WIDTH-1:0]   bitslip_s;
    logic                      slip_s;

    // The pulse is issued on the SLIP->WAIT edge; START suppresses it.
    assign slip_s = (state_r == ST_SLIP) && (slip_cnt_r != SW'(P_MAX_SLIP)) && !START;

    lvds_lane_mux #(
        .C_DATA_WIDTH (C_DATA_WIDTH),
        .LW           (LW)
    ) u_lane_mux (
        .rx_q    (rx_q_r),
        .lane    (lane_r),
        .slip    (slip_s),
        .word    (word_s),
        .lane_oh (lane_oh_s),
        .bitslip (bitslip_s)
    );

    // Input capture and downstream data forwarding
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rx_q_r   <= '0;
            RX_DAT_O <= '0;
        end else begin
            rx_q_r   <= RX_DAT;
            RX_DAT_O <= RX_DAT;
        end
    end

    // Training FSM, counters and status outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r     <= ST_IDLE;
            lane_r      <= '0;
            slip_cnt_r  <= '0;
            match_cnt_r <= '0;
            wait_cnt_r  <= '0;
            BITSLIP     <= '0;
            LANE_LOCK   <= '0;
            ALIGN_DONE  <= 1'b0;
            ALIGN_FAIL  <= 1'b0;
            FAIL_LANE   <= '0;
            RX_VLD      <= 1'b0;
        end else begin
            BITSLIP <= bitslip_s;
            RX_VLD  <= ALIGN_DONE;
            if (START) begin
                state_r     <= ST_CHECK;
                lane_r      <= '0;
                slip_cnt_r  <= '0;
                match_cnt_r <= '0;
                wait_cnt_r  <= '0;
                LANE_LOCK   <= '0;
                ALIGN_DONE  <= 1'b0;
                ALIGN_FAIL  <= 1'b0;
                FAIL_LANE   <= '0;
                RX_VLD      <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        state_r <= ST_IDLE;
                    end
                    ST_CHECK: begin
                        if (word_s == P_TRAIN_PAT) begin
                            if (match_cnt_r == MW'(P_MATCH_CNT - 1)) begin
                                LANE_LOCK <= LANE_LOCK | lane_oh_s;
                                state_r   <= ST_NEXT;
                            end else begin
                                match_cnt_r <= match_cnt_r + MW'(1);
                            end
                        end else if (match_cnt_r != MW'(0)) begin
                            // Interrupted lock attempt: retry without slipping
                            match_cnt_r <= '0;
                        end else begin
                            state_r <= ST_SLIP;
                        end
                    end
                    ST_SLIP: begin
                        if (slip_cnt_r == SW'(P_MAX_SLIP)) begin
                            state_r    <= ST_FAIL;
                            ALIGN_FAIL <= 1'b1;
                            FAIL_LANE  <= lane_r;
                        end else begin
                            slip_cnt_r <= slip_cnt_r + SW'(1);
                            wait_cnt_r <= '0;
                            state_r    <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (wait_cnt_r == WW'(P_SLIP_WAIT - 1)) begin
                            match_cnt_r <= '0;
                            state_r     <= ST_CHECK;
                        end else begin
                            wait_cnt_r <= wait_cnt_r + WW'(1);
                        end
                    end
                    ST_NEXT: begin
                        if (lane_r == LW'(C_DATA_WIDTH - 1)) begin
                            ALIGN_DONE <= 1'b1;
                            state_r    <= ST_DONE;
                        end else begin
                            lane_r      <= lane_r + LW'(1);
                            slip_cnt_r  <= '0;
                            match_cnt_r <= '0;
                            state_r     <= ST_CHECK;
                        end
                    end
                    ST_DONE: begin
                        state_r <= ST_DONE;
                    end
                    ST_FAIL: begin
                        state_r <= ST_FAIL;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
